// File: rtl/mac_package.sv
// Shared constants and payload type for the TCDM arbiter slice.
//   TCDM_ADDR_W / TCDM_DATA_W / TCDM_BE_W : TCDM bus field widths
//   tcdm_payload_t                        : address/wen/be/data bundle of one request
//   id_width()                            : bits needed to name one of n ports
package mac_package;

   localparam int unsigned TCDM_ADDR_W = 32;
   localparam int unsigned TCDM_DATA_W = 32;
   localparam int unsigned TCDM_BE_W   = 4;

   typedef struct packed {
      logic [TCDM_ADDR_W-1:0] add;
      logic                   wen;
      logic [TCDM_BE_W-1:0]   be;
      logic [TCDM_DATA_W-1:0] data;
   } tcdm_payload_t;

   // A single port still needs a 1-bit ID so the FIFO has a non-zero width.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mac_tcdm_id_fifo.sv
// Synchronous FIFO holding the port IDs of outstanding memory transactions.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push, wdata   : enqueue an ID (ignored when full)
//   pop           : dequeue the head (ignored when empty)
//   rdata         : current head ID
//   full, empty   : occupancy flags
module mac_tcdm_id_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push_ok;
   logic          pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop_ok)      cnt <= cnt + CW'(1);
         else if (!push_ok && pop_ok) cnt <= cnt - CW'(1);
      end
   end

   // Storage needs no reset; only entries below the write pointer are read.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mac_tcdm_arbiter.sv
// Round-robin arbiter funnelling MP TCDM master ports onto one memory port.
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   tcdm_req/add/wen/be/data: per-port requests from the engine
//   tcdm_gnt                : same-cycle grant to the winning port
//   tcdm_r_data/r_valid     : response, data broadcast, valid routed to issuer
//   mem_req/add/wen/be/data : winner's request toward memory; mem_gnt accepts
//   mem_r_data/r_valid      : in-order memory response
//   err_o                   : sticky, set by a response with nothing outstanding
module mac_tcdm_arbiter
   import mac_package::*;
#(
   parameter int unsigned MP         = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [MP-1:0]                   tcdm_req,
   output logic [MP-1:0]                   tcdm_gnt,
   input  logic [MP-1:0][TCDM_ADDR_W-1:0]  tcdm_add,
   input  logic [MP-1:0]                   tcdm_wen,
   input  logic [MP-1:0][TCDM_BE_W-1:0]    tcdm_be,
   input  logic [MP-1:0][TCDM_DATA_W-1:0]  tcdm_data,
   output logic [MP-1:0][TCDM_DATA_W-1:0]  tcdm_r_data,
   output logic [MP-1:0]                   tcdm_r_valid,
   output logic                            mem_req,
   input  logic                            mem_gnt,
   output logic [TCDM_ADDR_W-1:0]          mem_add,
   output logic                            mem_wen,
   output logic [TCDM_BE_W-1:0]            mem_be,
   output logic [TCDM_DATA_W-1:0]          mem_data,
   input  logic [TCDM_DATA_W-1:0]          mem_r_data,
   input  logic                            mem_r_valid,
   output logic                            err_o
);

   localparam int unsigned IDW = id_width(MP);

   logic [IDW-1:0] rr;
   logic [IDW-1:0] winner;
   logic           any_req;
   logic           handshake;
   logic           pop;
   logic [IDW-1:0] head;
   logic           fifo_full;
   logic           fifo_empty;
   tcdm_payload_t  win_pl;
   int unsigned    idx;

   // First requester at or above rr, wrapping modulo MP.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < MP; i++) begin
         idx = (32'(rr) + i) % MP;
         if (!any_req && tcdm_req[IDW'(idx)]) begin
            any_req = 1'b1;
            winner  = IDW'(idx);
         end
      end
   end

   // Full FIFO blocks issue even if a response frees a slot this cycle.
   assign mem_req   = rst_ni && any_req && !fifo_full;
   assign handshake = mem_req && mem_gnt;
   assign pop       = rst_ni && mem_r_valid && !fifo_empty;

   always_comb begin
      win_pl = '0;
      if (any_req) begin
         win_pl.add  = tcdm_add[winner];
         win_pl.wen  = tcdm_wen[winner];
         win_pl.be   = tcdm_be[winner];
         win_pl.data = tcdm_data[winner];
      end
   end

   assign mem_add  = win_pl.add;
   assign mem_wen  = win_pl.wen;
   assign mem_be   = win_pl.be;
   assign mem_data = win_pl.data;

   // One-hot grant and response-valid, each at most one bit per cycle.
   always_comb begin
      tcdm_gnt     = '0;
      tcdm_r_valid = '0;
      if (handshake) tcdm_gnt[winner]   = 1'b1;
      if (pop)       tcdm_r_valid[head] = 1'b1;
   end

   always_comb begin
      for (int unsigned p = 0; p < MP; p++) tcdm_r_data[p] = mem_r_data;
   end

   // Pointer moves past the winner only on an accepted request.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr <= '0;
      end else if (handshake) begin
         rr <= (winner == IDW'(MP - 1)) ? '0 : winner + IDW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_o <= 1'b0;
      end else if (mem_r_valid && fifo_empty) begin
         err_o <= 1'b1;
      end
   end

   mac_tcdm_id_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (IDW)
   ) i_id_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (handshake),
      .wdata  (winner),
      .pop    (pop),
      .rdata  (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

endmodule

// File: tb/tb_mac_tcdm_arbiter.sv
// Self-checking bench for mac_tcdm_arbiter (MP=4, FIFO_DEPTH=4).
module tb_mac_tcdm_arbiter;

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic [3:0]          tcdm_req;
   logic [3:0]          tcdm_gnt;
   logic [3:0][31:0]    tcdm_add;
   logic [3:0]          tcdm_wen;
   logic [3:0][3:0]     tcdm_be;
   logic [3:0][31:0]    tcdm_data;
   logic [3:0][31:0]    tcdm_r_data;
   logic [3:0]          tcdm_r_valid;
   logic                mem_req;
   logic                mem_gnt;
   logic [31:0]         mem_add;
   logic                mem_wen;
   logic [3:0]          mem_be;
   logic [31:0]         mem_data;
   logic [31:0]         mem_r_data;
   logic                mem_r_valid;
   logic                err_o;

   int n_cmp = 0;
   int n_mis = 0;
   int sb_q[$];

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic        mg;
      logic        rsp;
      logic [31:0] rdata;
      logic [3:0]  egnt;
      logic        emreq;
      logic        eerr;
   } vec_t;

   vec_t vt[$];

   always #5 clk_i = ~clk_i;

   mac_tcdm_arbiter #(.MP(4), .FIFO_DEPTH(4)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .tcdm_req     (tcdm_req),
      .tcdm_gnt     (tcdm_gnt),
      .tcdm_add     (tcdm_add),
      .tcdm_wen     (tcdm_wen),
      .tcdm_be      (tcdm_be),
      .tcdm_data    (tcdm_data),
      .tcdm_r_data  (tcdm_r_data),
      .tcdm_r_valid (tcdm_r_valid),
      .mem_req      (mem_req),
      .mem_gnt      (mem_gnt),
      .mem_add      (mem_add),
      .mem_wen      (mem_wen),
      .mem_be       (mem_be),
      .mem_data     (mem_data),
      .mem_r_data   (mem_r_data),
      .mem_r_valid  (mem_r_valid),
      .err_o        (err_o)
   );

   function automatic logic [31:0] exp_add(input int p);
      return 32'h1000_0000 + 32'(p * 16);
   endfunction

   function automatic logic [31:0] exp_data(input int p);
      return 32'hD000_0000 | 32'(p);
   endfunction

   function automatic logic [3:0] exp_be(input int p);
      return 4'b0001 << p;
   endfunction

   function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic mg,
                               input logic rsp, input logic [31:0] rdata,
                               input logic [3:0] egnt, input logic emreq, input logic eerr);
      vec_t v;
      v.rst = rst; v.req = req; v.mg = mg; v.rsp = rsp; v.rdata = rdata;
      v.egnt = egnt; v.emreq = emreq; v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive after the rising edge, check combinational and registered
   // outputs on the falling edge. The scoreboard holds expected responder ports.
   task automatic step(input vec_t v, input string name);
      logic [3:0]   erv;
      logic [127:0] rd_exp;
      int           p;
      @(posedge clk_i);
      #1;
      rst_ni      = !v.rst;
      tcdm_req    = v.req;
      mem_gnt     = v.mg;
      mem_r_valid = v.rsp;
      mem_r_data  = v.rdata;
      erv = '0;
      if (v.rst) sb_q.delete();
      else if (v.rsp && sb_q.size() > 0) begin
         p = sb_q.pop_front();
         erv[p] = 1'b1;
      end
      @(negedge clk_i);
      chk({name, ".gnt"},     72'(tcdm_gnt),     72'(v.egnt));
      chk({name, ".mem_req"}, 72'(mem_req),      72'(v.emreq));
      chk({name, ".r_valid"}, 72'(tcdm_r_valid), 72'(erv));
      chk({name, ".err"},     72'(err_o),        72'(v.eerr));
      if (erv != '0) begin
         rd_exp = {v.rdata, v.rdata, v.rdata, v.rdata};
         chk({name, ".r_data"}, 72'(tcdm_r_data[3:2]), 72'(rd_exp[127:64]));
         chk({name, ".r_data"}, 72'(tcdm_r_data[1:0]), 72'(rd_exp[63:0]));
      end
      if (v.egnt != '0) begin
         p = 0;
         for (int i = 0; i < 4; i++) if (v.egnt[i]) p = i;
         chk({name, ".mem_pl"}, 72'({mem_add, mem_wen, mem_be, mem_data}),
             72'({exp_add(p), p[0], exp_be(p), exp_data(p)}));
         sb_q.push_back(p);
      end else if (v.req == '0 && !v.rst) begin
         chk({name, ".mem_pl_zero"}, 72'({mem_add, mem_wen, mem_be, mem_data}), 72'(0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni      = 1'b0;
      tcdm_req    = '0;
      mem_gnt     = 1'b0;
      mem_r_valid = 1'b0;
      mem_r_data  = '0;
      for (int p = 0; p < 4; p++) begin
         tcdm_add[p]  = exp_add(p);
         tcdm_wen[p]  = p[0];
         tcdm_be[p]   = exp_be(p);
         tcdm_data[p] = exp_data(p);
      end

      // Ports 0 and 2, one-cycle latency.
      vt.push_back(mk(1, 4'b1111, 1, 1, 32'h0BAD_0000, 4'b0000, 0, 0));
      vt.push_back(mk(0, 4'b0101, 1, 0, 32'h0,         4'b0001, 1, 0));
      vt.push_back(mk(0, 4'b0100, 1, 1, 32'h1111_0000, 4'b0100, 1, 0));
      vt.push_back(mk(0, 4'b0000, 1, 1, 32'h2222_0000, 4'b0000, 0, 0));
      // All four ports requesting continuously.
      vt.push_back(mk(1, 4'b1111, 1, 1, 32'h0BAD_0001, 4'b0000, 0, 0));
      vt.push_back(mk(0, 4'b1111, 1, 0, 32'h0,         4'b0001, 1, 0));
      vt.push_back(mk(0, 4'b1111, 1, 1, 32'h3333_0001, 4'b0010, 1, 0));
      vt.push_back(mk(0, 4'b1111, 1, 1, 32'h3333_0002, 4'b0100, 1, 0));
      vt.push_back(mk(0, 4'b1111, 1, 1, 32'h3333_0003, 4'b1000, 1, 0));
      vt.push_back(mk(0, 4'b1111, 1, 1, 32'h3333_0004, 4'b0001, 1, 0));
      vt.push_back(mk(0, 4'b1111, 1, 1, 32'h3333_0005, 4'b0010, 1, 0));
      vt.push_back(mk(0, 4'b0000, 1, 1, 32'h3333_0006, 4'b0000, 0, 0));
      // Memory stalls three cycles with port 1 waiting.
      vt.push_back(mk(1, 4'b1111, 1, 1, 32'h0BAD_0002, 4'b0000, 0, 0));
      vt.push_back(mk(0, 4'b0010, 0, 0, 32'h0,         4'b0000, 1, 0));
      vt.push_back(mk(0, 4'b0010, 0, 0, 32'h0,         4'b0000, 1, 0));
      vt.push_back(mk(0, 4'b0010, 0, 0, 32'h0,         4'b0000, 1, 0));
      vt.push_back(mk(0, 4'b0010, 1, 0, 32'h0,         4'b0010, 1, 0));
      vt.push_back(mk(0, 4'b0000, 1, 1, 32'h4444_0001, 4'b0000, 0, 0));

      for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("vec%0d", i));

      // FIFO fills after four grants; a response frees a slot only next cycle.
      step(mk(1, 4'b1111, 1, 1, 32'h0BAD_0003, 4'b0000, 0, 0), "full.rst");
      step(mk(0, 4'b1111, 1, 0, 32'h0,         4'b0001, 1, 0), "full.g0");
      step(mk(0, 4'b1111, 1, 0, 32'h0,         4'b0010, 1, 0), "full.g1");
      step(mk(0, 4'b1111, 1, 0, 32'h0,         4'b0100, 1, 0), "full.g2");
      step(mk(0, 4'b1111, 1, 0, 32'h0,         4'b1000, 1, 0), "full.g3");
      step(mk(0, 4'b1111, 1, 0, 32'h0,         4'b0000, 0, 0), "full.stall");
      step(mk(0, 4'b1111, 1, 1, 32'hA5A5_A5A5, 4'b0000, 0, 0), "full.pop");
      step(mk(0, 4'b1111, 1, 0, 32'h0,         4'b0001, 1, 0), "full.reissue");
      step(mk(0, 4'b0000, 1, 1, 32'h5555_0001, 4'b0000, 0, 0), "full.drain1");
      step(mk(0, 4'b0000, 1, 1, 32'h5555_0002, 4'b0000, 0, 0), "full.drain2");
      step(mk(0, 4'b0000, 1, 1, 32'h5555_0003, 4'b0000, 0, 0), "full.drain3");
      step(mk(0, 4'b0000, 1, 1, 32'h5555_0004, 4'b0000, 0, 0), "full.drain4");

      // Response with nothing outstanding sets a sticky error.
      step(mk(0, 4'b0000, 1, 1, 32'h6666_0001, 4'b0000, 0, 0), "spur.resp");
      step(mk(0, 4'b0000, 1, 0, 32'h0,         4'b0000, 0, 1), "spur.err1");
      step(mk(0, 4'b0000, 1, 0, 32'h0,         4'b0000, 0, 1), "spur.err2");

      // Reset with two outstanding drops them; late responses are spurious.
      step(mk(1, 4'b1111, 1, 1, 32'h0BAD_0004, 4'b0000, 0, 1), "mid.rst0");
      step(mk(0, 4'b0011, 1, 0, 32'h0,         4'b0001, 1, 0), "mid.g0");
      step(mk(0, 4'b0010, 1, 0, 32'h0,         4'b0010, 1, 0), "mid.g1");
      step(mk(1, 4'b1111, 1, 1, 32'h0BAD_0005, 4'b0000, 0, 0), "mid.rst1");
      step(mk(0, 4'b0000, 1, 1, 32'h7777_0001, 4'b0000, 0, 0), "mid.late1");
      step(mk(0, 4'b0000, 1, 1, 32'h7777_0002, 4'b0000, 0, 1), "mid.late2");
      step(mk(0, 4'b0110, 1, 0, 32'h0,         4'b0010, 1, 1), "mid.rr0");
      step(mk(0, 4'b0000, 1, 1, 32'h7777_0003, 4'b0000, 0, 1), "mid.drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mac_tcdm_arbiter.md
MAC_TCDM_ARBITER -- requirements
Module: mac_tcdm_arbiter

Interface
REQ-001 Parameter MP, default 4: number of TCDM master ports on the engine side.
REQ-002 Parameter FIFO_DEPTH, default 4: maximum outstanding memory transactions (power of two, >=2).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 tcdm_req  in  MP  per-port request.
REQ-006 tcdm_gnt  out  MP  per-port grant; at most one bit high per cycle.
REQ-007 tcdm_add  in  MPx32  per-port byte address.
REQ-008 tcdm_wen  in  MP  per-port write enable, active-low (1 = read, 0 = write).
REQ-009 tcdm_be  in  MPx4  per-port byte enables.
REQ-010 tcdm_data  in  MPx32  per-port write data.
REQ-011 tcdm_r_data  out  MPx32  response data, broadcast identically to all ports.
REQ-012 tcdm_r_valid  out  MP  per-port response valid; at most one bit high per cycle.
REQ-013 mem_req  out  1  memory request; mem_gnt  in  1  memory grant.
REQ-014 mem_add  out  32; mem_wen  out  1; mem_be  out  4; mem_data  out  32: winner's fields.
REQ-015 mem_r_data  in  32; mem_r_valid  in  1: memory response, in issue order, latency >=1 cycle.
REQ-016 err_o  out  1  sticky flag: response received with no transaction outstanding.

Function
REQ-017 Winner = first port with tcdm_req high scanning from pointer rr upward, modulo MP; combinational.
REQ-018 mem_req = (any tcdm_req) AND NOT fifo_full; mem_add/wen/be/data = winner's fields, zero when no request.
REQ-019 tcdm_gnt[winner] = mem_req AND mem_gnt; all other grant bits 0 (same cycle, no added latency).
REQ-020 Handshake (mem_req AND mem_gnt): push winner index into ID FIFO; rr <= (winner+1) mod MP.
REQ-021 No handshake: rr unchanged; a requesting port keeps its address/data stable until granted (master rule, not checked).
REQ-022 mem_r_valid with FIFO non-empty: tcdm_r_valid[head] = 1 same cycle, tcdm_r_data = mem_r_data, pop head.
REQ-023 Both reads and writes produce exactly one tcdm_r_valid pulse.
REQ-024 FIFO full: mem_req forced 0 even if a pop occurs the same cycle (no push-on-pop bypass).
REQ-025 Simultaneous push and pop on non-full FIFO: both performed, occupancy unchanged.
REQ-026 mem_r_valid with FIFO empty: ignored (tcdm_r_valid all 0), err_o <= 1.
REQ-027 rr wraps from MP-1 to 0; single requester is granted every cycle while mem_gnt high and FIFO not full.

Reset
REQ-028 On rst_ni low at clock edge: rr = 0, FIFO empty (pointers and count 0), err_o = 0.
REQ-029 During reset: mem_req, tcdm_gnt, tcdm_r_valid = 0; tcdm_r_data = mem_r_data pass-through permitted.
REQ-030 Reset mid-operation discards outstanding IDs; late responses afterward follow REQ-026.

Structure
REQ-031 Constants TCDM_ADDR_W=32, TCDM_DATA_W=32, TCDM_BE_W=4 belong in mac_package.
REQ-032 One sub-module mac_tcdm_id_fifo: synchronous FIFO of $clog2(MP)-bit entries, FIFO_DEPTH deep, full/empty outputs.
REQ-033 Arbitration and response routing live in mac_tcdm_arbiter; no other sub-modules.

Verification
REQ-034 Reset, then ports 0,2 request, mem_gnt=1, 1-cycle latency -> grants port0 cycle 0, port2 cycle 1; r_valid port0 cycle 1, port2 cycle 2.
REQ-035 All 4 ports request continuously, mem_gnt=1 -> grant sequence 0,1,2,3,0,... with exactly one grant per cycle.
REQ-036 mem_gnt=0 for 3 cycles with port1 requesting -> no tcdm_gnt, rr stays 0; grant to port1 on 4th cycle.
REQ-037 FIFO_DEPTH=4, responses withheld -> exactly 4 grants then mem_req=0; one mem_r_valid (data 0xA5A5A5A5) -> r_valid to first grantee, next cycle mem_req=1.
REQ-038 mem_r_valid with FIFO empty -> no tcdm_r_valid, err_o=1 next cycle, stays 1 until reset.
REQ-039 Reset asserted with 2 outstanding -> FIFO empty, rr=0, err_o=0; following 2 responses set err_o, no r_valid.
